bg_win_fetcher: RTL and testbench

Parametrised background/window tile fetcher for the PPU pixel pipeline. During mode 3 it walks the active tile map, reads each tile's index and two bitplane bytes from VRAM, and pushes a row of decoded pixels into the BG FIFO. It supersedes the BG-only fetcher: it adds window switching with an internal window-line counter, a configurable step length, a parametrised pixel word, and optional CGB attribute fetch.

---
 rtl/bg_win_fetcher.sv | 242 ++++++++++++++++++++++++
 tb/tb_bg_win_fetcher.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_win_fetcher.sv
// Background/window tile fetcher for the PPU pixel pipeline.
// Walks the active tile map during mode 3, reads tile index and both bitplanes
// from VRAM and pushes one decoded row of pixels into the BG FIFO.
// Optional CGB attribute fetch is enabled by defining CGB_ATTR_EN; without it
// there is no attribute step, vram_bank stays 0 and palette/priority are 0.
//
// state    | meaning
// IDLE     | outside mode 3, no fetching
// GET_TILE | read tile index from the map
// GET_ATTR | read CGB attribute byte from bank 1 (CGB_ATTR_EN only)
// GET_LOW  | read low bitplane byte
// GET_HIGH | read high bitplane byte
// PUSH     | wait for an empty FIFO, then push the decoded row
module bg_win_fetcher #(
    parameter int STEP_DOTS = 2,
    parameter int PUSH_W    = 8,
    parameter int PAL_W     = 3,
    localparam int PIX_W    = PAL_W + 3
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      line_end_i,
    input  logic                      frame_start_i,
    input  logic                      win_trigger_i,
    input  logic [7:0]                lcdc_i,
    input  logic [7:0]                scx_i,
    input  logic [7:0]                scy_i,
    input  logic [7:0]                ly_i,
    input  logic [7:0]                vram_rdata_i,
    input  logic                      fifo_empty_i,
    output logic                      vram_req_o,
    output logic [15:0]               vram_addr_o,
    output logic                      vram_bank_o,
    output logic                      fifo_push_o,
    output logic [PUSH_W*PIX_W-1:0]   fifo_data_o,
    output logic                      win_active_o,
    output logic                      busy_o
);

    localparam int DOT_W = (STEP_DOTS > 1) ? $clog2(STEP_DOTS) : 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TILE = 3'd1;
    localparam logic [2:0] ST_LOW  = 3'd2;
    localparam logic [2:0] ST_HIGH = 3'd3;
    localparam logic [2:0] ST_PUSH = 3'd4;
`ifdef CGB_ATTR_EN
    localparam logic [2:0] ST_ATTR = 3'd5;
`endif

    logic [2:0]              state_q;
    logic [DOT_W-1:0]        dot_q;
    logic [4:0]              col_q;
    logic                    win_q;
    logic                    win_seen_q;
    logic [7:0]              win_line_q;
    logic [7:0]              idx_q;
    logic [7:0]              low_q;
    logic [7:0]              high_q;
    logic                    fifo_push_q;
    logic [PUSH_W*PIX_W-1:0] fifo_data_q;

    logic                    fetching;
    logic                    step_last;
    logic [7:0]              row;
    logic [2:0]              fine_row;
    logic                    map_sel;
    logic [15:0]             map_addr;
    logic [15:0]             tile_base;
    logic [15:0]             low_addr;
    logic [15:0]             high_addr;
    logic [PUSH_W*PIX_W-1:0] pix_row;

    logic                    attr_prio;
    logic                    attr_vflip;
    logic                    attr_hflip;
    logic                    attr_bank;
    logic [PAL_W-1:0]        attr_pal;
    logic                    unused_bits;

`ifdef CGB_ATTR_EN
    logic [7:0] attr_q;
    logic       unused_attr;
    assign attr_prio   = attr_q[7];
    assign attr_vflip  = attr_q[6];
    assign attr_hflip  = attr_q[5];
    assign attr_bank   = attr_q[3];
    assign attr_pal    = PAL_W'(attr_q[2:0]);
    assign unused_attr = attr_q[4];
`else
    assign attr_prio  = 1'b0;
    assign attr_vflip = 1'b0;
    assign attr_hflip = 1'b0;
    assign attr_bank  = 1'b0;
    assign attr_pal   = '0;
`endif

    assign unused_bits = ^{lcdc_i[7], lcdc_i[2:0], scx_i[2:0]};

    assign fetching  = (state_q == ST_TILE) || (state_q == ST_LOW) || (state_q == ST_HIGH)
`ifdef CGB_ATTR_EN
                       || (state_q == ST_ATTR)
`endif
                       ;
    assign step_last = (dot_q == DOT_W'(STEP_DOTS - 1));

    // Map and tile-data address generation from the live PPU registers.
    always_comb begin
        row       = win_q ? win_line_q : (scy_i + ly_i);
        fine_row  = attr_vflip ? ~row[2:0] : row[2:0];
        map_sel   = win_q ? lcdc_i[6] : lcdc_i[3];
        map_addr  = {5'b10011, map_sel, row[7:3], col_q};
        tile_base = lcdc_i[4] ? {4'h8, idx_q, 4'h0}
                              : 16'h9000 + {{4{idx_q[7]}}, idx_q, 4'h0};
        low_addr  = tile_base + {12'h000, fine_row, 1'b0};
        high_addr = low_addr + 16'd1;
    end

    // VRAM request: address held for the whole step, strobe on its first dot.
    always_comb begin
        vram_addr_o = 16'h0000;
        vram_bank_o = 1'b0;
        case (state_q)
            ST_TILE: vram_addr_o = map_addr;
`ifdef CGB_ATTR_EN
            ST_ATTR: begin
                vram_addr_o = map_addr;
                vram_bank_o = 1'b1;
            end
`endif
            ST_LOW: begin
                vram_addr_o = low_addr;
                vram_bank_o = attr_bank;
            end
            ST_HIGH: begin
                vram_addr_o = high_addr;
                vram_bank_o = attr_bank;
            end
            default: ;
        endcase
    end

    assign vram_req_o = fetching && (dot_q == '0);

    // Decode the two bitplanes into pixel words, slot 0 leftmost.
    always_comb begin
        logic [2:0] b;
        pix_row = '0;
        for (int i = 0; i < PUSH_W; i++) begin
            b = attr_hflip ? 3'(i) : 3'(7 - i);
            pix_row[i*PIX_W +: PIX_W] = {attr_prio, attr_pal, high_q[b], low_q[b]};
        end
    end

    // Fetch sequencing, event priority and window line counting.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            dot_q       <= '0;
            col_q       <= 5'd0;
            win_q       <= 1'b0;
            win_seen_q  <= 1'b0;
            win_line_q  <= 8'd0;
            idx_q       <= 8'd0;
            low_q       <= 8'd0;
            high_q      <= 8'd0;
            fifo_push_q <= 1'b0;
            fifo_data_q <= '0;
`ifdef CGB_ATTR_EN
            attr_q      <= 8'd0;
`endif
        end else begin
            fifo_push_q <= 1'b0;
            if (frame_start_i) begin
                win_line_q <= 8'd0;
            end
            if (line_end_i) begin
                if (!frame_start_i && win_seen_q) begin
                    win_line_q <= win_line_q + 8'd1;
                end
                state_q    <= ST_IDLE;
                dot_q      <= '0;
                win_q      <= 1'b0;
                win_seen_q <= 1'b0;
            end else if (win_trigger_i && lcdc_i[5] && (state_q != ST_IDLE)) begin
                state_q    <= ST_TILE;
                dot_q      <= '0;
                col_q      <= 5'd0;
                win_q      <= 1'b1;
                win_seen_q <= 1'b1;
            end else if (start_i) begin
                state_q <= ST_TILE;
                dot_q   <= '0;
                col_q   <= scx_i[7:3];
                win_q   <= 1'b0;
            end else if (fetching) begin
                if (step_last) begin
                    dot_q <= '0;
                    case (state_q)
                        ST_TILE: begin
                            idx_q <= vram_rdata_i;
`ifdef CGB_ATTR_EN
                            state_q <= ST_ATTR;
`else
                            state_q <= ST_LOW;
`endif
                        end
`ifdef CGB_ATTR_EN
                        ST_ATTR: begin
                            attr_q  <= vram_rdata_i;
                            state_q <= ST_LOW;
                        end
`endif
                        ST_LOW: begin
                            low_q   <= vram_rdata_i;
                            state_q <= ST_HIGH;
                        end
                        default: begin
                            high_q  <= vram_rdata_i;
                            state_q <= ST_PUSH;
                        end
                    endcase
                end else begin
                    dot_q <= dot_q + DOT_W'(1);
                end
            end else if ((state_q == ST_PUSH) && fifo_empty_i) begin
                fifo_push_q <= 1'b1;
                fifo_data_q <= pix_row;
                col_q       <= col_q + 5'd1;
                state_q     <= ST_TILE;
                dot_q       <= '0;
            end
        end
    end

    assign fifo_push_o  = fifo_push_q;
    assign fifo_data_o  = fifo_data_q;
    assign win_active_o = win_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bg_win_fetcher.sv
// Self-checking bench for bg_win_fetcher: a cycle-indexed behavioural model
// compared every cycle, plus directed literal expectations.
module tb_bg_win_fetcher;

    localparam int SD    = 2;
    localparam int PW    = 8;
    localparam int PIX_W = 6;
`ifdef CGB_ATTR_EN
    localparam int NF = 4;
`else
    localparam int NF = 3;
`endif
    localparam int K_TILE = 0, K_ATTR = 1, K_LOW = 2, K_HIGH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, start = 1'b0, line_end = 1'b0, frame_start = 1'b0, win_trigger = 1'b0;
    logic [7:0] lcdc = 8'h91, scx = 8'h13, scy = 8'h05, ly = 8'h02;
    logic [7:0] vram_rdata = 8'h00;
    logic fifo_empty = 1'b0;
    logic vram_req, vram_bank, fifo_push, win_active, busy;
    logic [15:0] vram_addr;
    logic [PW*PIX_W-1:0] fifo_data;

    bg_win_fetcher #(.STEP_DOTS(SD), .PUSH_W(PW), .PAL_W(3)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .line_end_i(line_end),
        .frame_start_i(frame_start), .win_trigger_i(win_trigger),
        .lcdc_i(lcdc), .scx_i(scx), .scy_i(scy), .ly_i(ly),
        .vram_rdata_i(vram_rdata), .fifo_empty_i(fifo_empty),
        .vram_req_o(vram_req), .vram_addr_o(vram_addr), .vram_bank_o(vram_bank),
        .fifo_push_o(fifo_push), .fifo_data_o(fifo_data),
        .win_active_o(win_active), .busy_o(busy)
    );

    logic [7:0] mem [0:131071];
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // VRAM responder: data for a request appears within the request dot.
    always @(negedge clk) begin
        if (vram_req === 1'b1) vram_rdata = mem[{vram_bank, vram_addr}];
    end

    // ---------------- behavioural model ----------------
    logic       model_valid = 1'b0;
    logic       m_busy, m_win, m_seen, m_push;
    int         m_k, m_col, m_wl;
    logic [7:0] m_idx, m_attr, m_low, m_high;
    logic [PW*PIX_W-1:0] m_data;

    function automatic int kind_of(input int step);
`ifdef CGB_ATTR_EN
        return step;
`else
        return (step == 0) ? K_TILE : step + 1;
`endif
    endfunction

    function automatic logic [16:0] m_addr(input int kind);
        int row, fine, base, sidx, a;
        logic bank;
        row = m_win ? m_wl : (int'(scy) + int'(ly)) % 256;
        if (kind == K_TILE || kind == K_ATTR) begin
            base = (m_win ? lcdc[6] : lcdc[3]) ? 'h9C00 : 'h9800;
            a    = base + (row / 8) * 32 + m_col;
            bank = (kind == K_ATTR);
        end else begin
            fine = row % 8;
            bank = 1'b0;
`ifdef CGB_ATTR_EN
            if (m_attr[6]) fine = 7 - fine;
            bank = m_attr[3];
`endif
            sidx = int'(m_idx);
            if (!lcdc[4] && sidx >= 128) sidx = sidx - 256;
            base = lcdc[4] ? 'h8000 : 'h9000;
            a    = (base + sidx * 16 + fine * 2 + ((kind == K_HIGH) ? 1 : 0)) & 'hFFFF;
        end
        return {bank, a[15:0]};
    endfunction

    function automatic logic [PW*PIX_W-1:0] m_decode();
        logic [PW*PIX_W-1:0] d;
        logic prio, hflip;
        logic [2:0] pal;
        int b;
        d = '0; prio = 1'b0; hflip = 1'b0; pal = 3'd0;
`ifdef CGB_ATTR_EN
        prio = m_attr[7]; hflip = m_attr[5]; pal = m_attr[2:0];
`endif
        for (int i = 0; i < PW; i++) begin
            b = hflip ? i : 7 - i;
            d[i*PIX_W +: PIX_W] = {prio, pal, m_high[b], m_low[b]};
        end
        return d;
    endfunction

    // Compare this cycle's outputs with the model, then advance the model
    // using this cycle's inputs.
    always @(negedge clk) begin
        logic fetch, e_req;
        logic [16:0] ea;
        logic [7:0] byte_rd;
        int kind;
        if (model_valid) begin
            fetch = m_busy && (m_k < NF * SD);
            e_req = fetch && (m_k % SD == 0);
            ea    = fetch ? m_addr(kind_of(m_k / SD)) : 17'd0;
            check("req", vram_req, e_req);
            check("addr", vram_addr, ea[15:0]);
            check("bank", vram_bank, ea[16]);
            check("busy", busy, m_busy);
            check("win_active", win_active, m_win);
            check("push", fifo_push, m_push);
            check("data", fifo_data, m_data);
        end
        m_push = 1'b0;
        if (reset) begin
            m_busy = 0; m_win = 0; m_seen = 0; m_k = 0; m_col = 0; m_wl = 0;
            m_idx = 0; m_attr = 0; m_low = 0; m_high = 0; m_data = '0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (frame_start) m_wl = 0;
            if (line_end) begin
                if (!frame_start && m_seen) m_wl = (m_wl + 1) % 256;
                m_busy = 0; m_win = 0; m_seen = 0; m_k = 0;
            end else if (win_trigger && lcdc[5] && m_busy) begin
                m_k = 0; m_col = 0; m_win = 1; m_seen = 1;
            end else if (start) begin
                m_busy = 1; m_k = 0; m_col = int'(scx) / 8; m_win = 0;
            end else if (m_busy) begin
                if (m_k < NF * SD) begin
                    if (m_k % SD == SD - 1) begin
                        kind = kind_of(m_k / SD);
                        byte_rd = mem[m_addr(kind)];
                        case (kind)
                            K_TILE: m_idx  = byte_rd;
                            K_ATTR: m_attr = byte_rd;
                            K_LOW:  m_low  = byte_rd;
                            default: m_high = byte_rd;
                        endcase
                    end
                    m_k++;
                end else if (fifo_empty) begin
                    m_push = 1'b1;
                    m_data = m_decode();
                    m_col  = (m_col + 1) % 32;
                    m_k    = 0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_line_end();
        line_end = 1'b1; tick(); line_end = 1'b0;
    endtask

    task automatic pulse_trigger();
        win_trigger = 1'b1; tick(); win_trigger = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        ticks(2);
        reset = 1'b0;
        check("rst_req", vram_req, 1'b0);
        check("rst_addr", vram_addr, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_push", fifo_push, 1'b0);
        check("rst_data", fifo_data, '0);
        check("rst_win", win_active, 1'b0);
        check("rst_bank", vram_bank, 1'b0);

`ifndef CGB_ATTR_EN
        // BG fetch and full-FIFO stall
        mem[17'h09802] = 8'h01; mem[17'h0801E] = 8'hA5; mem[17'h0801F] = 8'h3C;
        pulse_start();
        check("bg_map_addr", vram_addr, 16'h9802);
        check("bg_map_req", vram_req, 1'b1);
        ticks(2);
        check("bg_low_addr", vram_addr, 16'h801E);
        ticks(2);
        check("bg_high_addr", vram_addr, 16'h801F);
        ticks(2);
        for (int c = 0; c < 4; c++) begin
            check("stall_push", fifo_push, 1'b0);
            check("stall_req", vram_req, 1'b0);
            tick();
        end
        fifo_empty = 1'b1;
        check("stall_last", fifo_push, 1'b0);
        tick();
        check("push_fire", fifo_push, 1'b1);
        check("slot0", fifo_data[0 +: PIX_W], 6'd1);
        check("slot2", fifo_data[2*PIX_W +: PIX_W], 6'd3);
        check("slot3", fifo_data[3*PIX_W +: PIX_W], 6'd2);
        check("slot7", fifo_data[7*PIX_W +: PIX_W], 6'd1);
        check("col_inc", vram_addr, 16'h9803);
        tick();
        check("push_one", fifo_push, 1'b0);

        // signed tile addressing and steady-state period
        pulse_line_end();
        lcdc = 8'h81; scx = 8'h00; scy = 8'h00; ly = 8'h03;
        mem[17'h09800] = 8'h80; mem[17'h08806] = 8'hC3; mem[17'h08807] = 8'h81;
        pulse_start();
        check("sgn_map", vram_addr, 16'h9800);
        ticks(2);
        check("sgn_low", vram_addr, 16'h8806);
        ticks(2);
        check("sgn_high", vram_addr, 16'h8807);
        ticks(3);
        check("period_first", fifo_push, 1'b1);
        for (int c = 9; c <= 15; c++) begin
            tick();
            check("period_next", fifo_push, c == 15);
        end

        // window switching and line counter
        pulse_line_end();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        lcdc = 8'hF1; scx = 8'h08; scy = 8'h00; ly = 8'h00;
        mem[17'h09C00] = 8'h02; mem[17'h08020] = 8'h0F; mem[17'h08021] = 8'hF0;
        mem[17'h08022] = 8'h55;
        pulse_trigger();
        check("win_idle_ignored", busy, 1'b0);
        pulse_start();
        check("win_bg_map", vram_addr, 16'h9801);
        ticks(2);
        check("win_bg_low", vram_addr, 16'h8000);
        pulse_trigger();
        check("win_map", vram_addr, 16'h9C00);
        check("win_flag", win_active, 1'b1);
        check("win_req", vram_req, 1'b1);
        ticks(2);
        check("win_low0", vram_addr, 16'h8020);
        ticks(6);
        pulse_line_end();
        check("le_idle", busy, 1'b0);
        check("le_win", win_active, 1'b0);
        pulse_start();
        pulse_trigger();
        check("win2_map", vram_addr, 16'h9C00);
        ticks(2);
        check("win_line_1", vram_addr, 16'h8022);
        ticks(4);
        line_end = 1'b1; frame_start = 1'b1; tick(); line_end = 1'b0; frame_start = 1'b0;
        pulse_start();
        pulse_trigger();
        ticks(2);
        check("win_line_clr", vram_addr, 16'h8020);

        // column wrap; window trigger ignored with window disabled
        pulse_line_end();
        lcdc = 8'h91; scx = 8'hF8; scy = 8'h00; ly = 8'h00;
        mem[17'h0981F] = 8'h03; mem[17'h09800] = 8'h00;
        pulse_start();
        check("wrap_col31", vram_addr, 16'h981F);
        ticks(2);
        pulse_trigger();
        check("trig_disabled", win_active, 1'b0);
        check("trig_dis_addr", vram_addr, 16'h8030);
        ticks(4);
        check("wrap_push", fifo_push, 1'b1);
        check("wrap_col0", vram_addr, 16'h9800);
`endif

        // reset in mid-fetch
        pulse_line_end();
        lcdc = 8'h91; scx = 8'h00; scy = 8'h00; ly = 8'h00;
        pulse_start();
        ticks(2);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_req", vram_req, 1'b0);
        check("mid_rst_addr", vram_addr, 16'h0000);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_data", fifo_data, '0);
        check("mid_rst_win", win_active, 1'b0);

`ifdef CGB_ATTR_EN
        // attribute fetch: vflip, hflip, bank 1, palette 3
        fifo_empty = 1'b1;
        lcdc = 8'h91; scx = 8'h00; scy = 8'h00; ly = 8'h01;
        mem[17'h09800] = 8'h01; mem[17'h19800] = 8'h6B;
        mem[17'h1801C] = 8'h01; mem[17'h1801D] = 8'h00;
        pulse_start();
        check("cgb_map", {vram_bank, vram_addr}, 17'h09800);
        ticks(2);
        check("cgb_attr", {vram_bank, vram_addr}, 17'h19800);
        ticks(2);
        check("cgb_low", {vram_bank, vram_addr}, 17'h1801C);
        ticks(5);
        check("cgb_push", fifo_push, 1'b1);
        check("cgb_slot0", fifo_data[0 +: PIX_W], 6'h0D);
        check("cgb_slot7", fifo_data[7*PIX_W +: PIX_W], 6'h0C);
        for (int c = 11; c <= 19; c++) begin
            tick();
            check("cgb_period", fifo_push, c == 19);
        end
`endif

        ticks(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
